// File: rtl/bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// bcd_timekeeper
// Keeps an HH:MM:SS.mmm time as nine BCD digits and runs it either as a
// 24-hour time-of-day clock or as a countdown timer that latches a done flag.
// Time advances on a 1 ms tick from an internal prescaler. In edit mode a
// cursor walks over the hour/minute (and optionally second) digits, and the
// centre/down buttons step the selected digit. The display outputs are
// registered one cycle behind the internal state.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   btn_l, btn_r, btn_c, btn_d  debounced button levels (edge-detected here)
//   fmt12                       1 = 12-hour display, 0 = 24-hour
//   mode                        0 = clock (count up), 1 = countdown
//   edit, cursor                edit-mode flag and selected digit index
//   hr_t..sec_o, ms_h..ms_o     displayed BCD digits
//   pm                          PM indicator (clock mode only)
//   done                        countdown reached zero
//   tick                        one-cycle pulse per 1 ms tick
// -----------------------------------------------------------------------------
module bcd_timekeeper #(
    parameter int PRESCALE = 100000,
    parameter int EDIT_SEC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    input  logic       btn_d,
    input  logic       fmt12,
    input  logic       mode,
    output logic       edit,
    output logic [2:0] cursor,
    output logic [3:0] hr_t,
    output logic [3:0] hr_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] ms_h,
    output logic [3:0] ms_t,
    output logic [3:0] ms_o,
    output logic       pm,
    output logic       done,
    output logic       tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [2:0] LAST_POS = (EDIT_SEC != 0) ? 3'd5 : 3'd3;

    // Digit slots inside the packed time register, most significant first.
    localparam int I_HR_T  = 8;
    localparam int I_HR_O  = 7;
    localparam int I_MIN_T = 6;
    localparam int I_MIN_O = 5;
    localparam int I_SEC_T = 4;
    localparam int I_SEC_O = 3;
    localparam int I_MS_H  = 2;
    localparam int I_MS_T  = 1;
    localparam int I_MS_O  = 0;

    // Roll-over value of each digit below the hours: index 6 (min_t) down to 0.
    localparam logic [6:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        S_EDIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      cursor_reg;
    logic [3:0]      btn_hist;
    logic [CW-1:0]   cnt;
    logic [8:0][3:0] tm;
    logic [8:0][3:0] inc_tm;
    logic [8:0][3:0] dec_tm;
    logic [8:0][3:0] edit_tm;
    logic [8:0][3:0] disp;
    logic            press_l;
    logic            press_r;
    logic            press_c;
    logic            press_d;
    logic            zero_time;
    logic            running;
    logic [3:0]      hr_o_max;
    logic [4:0]      hour_bin;
    logic [4:0]      disp_bin;
    logic [3:0]      disp_hr_t;
    logic [3:0]      disp_hr_o;
    logic            carry;
    logic            borrow;

    // Steps one edit digit up or down with wrap-around inside 0..maxv.
    function automatic logic [3:0] step_digit(input logic [3:0] d,
                                              input logic [3:0] maxv,
                                              input logic       up);
        if (up)
            return (d >= maxv) ? 4'd0 : d + 4'd1;
        return (d == 4'd0) ? maxv : d - 4'd1;
    endfunction

    assign press_l = btn_l & ~btn_hist[3];
    assign press_r = btn_r & ~btn_hist[2];
    assign press_c = btn_c & ~btn_hist[1];
    assign press_d = btn_d & ~btn_hist[0];

    assign zero_time = (tm == '0);

    // A countdown parked at zero must not tick; it drops into DONE instead.
    assign running = (state == S_RUN) && !(mode && zero_time);
    assign tick    = running && (cnt == CNT_MAX);

    assign hour_bin = 5'(tm[I_HR_T]) * 5'd10 + 5'(tm[I_HR_O]);

    // Count-up successor of the current time, rippling a carry from the
    // milliseconds into the hours; 23:59:59.999 wraps to all zeros.
    always_comb begin
        inc_tm = tm;
        carry  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (carry) begin
                if (tm[i] >= DIG_MAX[i]) begin
                    inc_tm[i] = 4'd0;
                end else begin
                    inc_tm[i] = tm[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        if (carry) begin
            if (tm[I_HR_T] == 4'd2 && tm[I_HR_O] >= 4'd3) begin
                inc_tm[I_HR_T] = 4'd0;
                inc_tm[I_HR_O] = 4'd0;
            end else if (tm[I_HR_O] >= 4'd9) begin
                inc_tm[I_HR_T] = tm[I_HR_T] + 4'd1;
                inc_tm[I_HR_O] = 4'd0;
            end else begin
                inc_tm[I_HR_O] = tm[I_HR_O] + 4'd1;
            end
        end
    end

    // Count-down predecessor of the current time with a borrow chain. The
    // all-zero case never reaches here while running, but wraps to 23:59:59.999.
    always_comb begin
        dec_tm = tm;
        borrow = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (borrow) begin
                if (tm[i] == 4'd0) begin
                    dec_tm[i] = DIG_MAX[i];
                end else begin
                    dec_tm[i] = tm[i] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
        if (borrow) begin
            if (tm[I_HR_O] != 4'd0) begin
                dec_tm[I_HR_O] = tm[I_HR_O] - 4'd1;
            end else if (tm[I_HR_T] != 4'd0) begin
                dec_tm[I_HR_T] = tm[I_HR_T] - 4'd1;
                dec_tm[I_HR_O] = 4'd9;
            end else begin
                dec_tm[I_HR_T] = 4'd2;
                dec_tm[I_HR_O] = 4'd3;
            end
        end
    end

    // Digit edit under the cursor. Only used when C or D is pressed, so
    // press_c alone decides the direction. Moving hr_t to 2 clamps hr_o so
    // the hour never exceeds 23.
    always_comb begin
        edit_tm  = tm;
        hr_o_max = (tm[I_HR_T] == 4'd2) ? 4'd3 : 4'd9;
        case (cursor_reg)
            3'd0: begin
                edit_tm[I_HR_T] = step_digit(tm[I_HR_T], 4'd2, press_c);
                if (edit_tm[I_HR_T] == 4'd2 && tm[I_HR_O] > 4'd3)
                    edit_tm[I_HR_O] = 4'd3;
            end
            3'd1:    edit_tm[I_HR_O]  = step_digit(tm[I_HR_O], hr_o_max, press_c);
            3'd2:    edit_tm[I_MIN_T] = step_digit(tm[I_MIN_T], 4'd5, press_c);
            3'd3:    edit_tm[I_MIN_O] = step_digit(tm[I_MIN_O], 4'd9, press_c);
            3'd4:    edit_tm[I_SEC_T] = step_digit(tm[I_SEC_T], 4'd5, press_c);
            3'd5:    edit_tm[I_SEC_O] = step_digit(tm[I_SEC_O], 4'd9, press_c);
            default: edit_tm = tm;
        endcase
    end

    // Hour shown on the display: 12-hour remap only in clock mode, raw
    // hours in countdown mode, then split back into two BCD digits.
    always_comb begin
        disp_bin = hour_bin;
        if (!mode && fmt12) begin
            if (hour_bin == 5'd0)
                disp_bin = 5'd12;
            else if (hour_bin > 5'd12)
                disp_bin = hour_bin - 5'd12;
        end
        if (disp_bin >= 5'd20) begin
            disp_hr_t = 4'd2;
            disp_hr_o = 4'(disp_bin - 5'd20);
        end else if (disp_bin >= 5'd10) begin
            disp_hr_t = 4'd1;
            disp_hr_o = 4'(disp_bin - 5'd10);
        end else begin
            disp_hr_t = 4'd0;
            disp_hr_o = 4'(disp_bin);
        end
    end

    // Main controller: button history, prescaler, EDIT/RUN/DONE state and
    // the time register. Button actions always take precedence over a tick
    // landing on the same edge, and leaving RUN restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EDIT;
            cursor_reg <= 3'd0;
            btn_hist   <= 4'd0;
            cnt        <= '0;
            tm         <= '0;
        end else begin
            btn_hist <= {btn_l, btn_r, btn_c, btn_d};
            if (running)
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            else
                cnt <= '0;

            case (state)
                S_EDIT: begin
                    if (press_l) begin
                        if (cursor_reg == 3'd0)
                            state <= S_RUN;
                        else
                            cursor_reg <= cursor_reg - 3'd1;
                    end else if (press_r) begin
                        if (cursor_reg >= LAST_POS) begin
                            state      <= S_RUN;
                            cursor_reg <= 3'd0;
                        end else begin
                            cursor_reg <= cursor_reg + 3'd1;
                        end
                    end else if (press_c || press_d) begin
                        tm <= edit_tm;
                    end
                end

                S_RUN: begin
                    if (press_d) begin
                        tm         <= '0;
                        state      <= S_EDIT;
                        cursor_reg <= 3'd0;
                        cnt        <= '0;
                    end else if (press_l) begin
                        tm[I_MS_H] <= 4'd0;
                        tm[I_MS_T] <= 4'd0;
                        tm[I_MS_O] <= 4'd0;
                        if (EDIT_SEC == 0) begin
                            tm[I_SEC_T] <= 4'd0;
                            tm[I_SEC_O] <= 4'd0;
                        end
                        state      <= S_EDIT;
                        cursor_reg <= 3'd0;
                        cnt        <= '0;
                    end else if (mode && zero_time) begin
                        state <= S_DONE;
                    end else if (tick) begin
                        if (!mode) begin
                            tm <= inc_tm;
                        end else begin
                            tm <= dec_tm;
                            if (dec_tm == '0)
                                state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (press_d) begin
                        tm         <= '0;
                        state      <= S_EDIT;
                        cursor_reg <= 3'd0;
                    end else if (press_l) begin
                        state      <= S_EDIT;
                        cursor_reg <= 3'd0;
                    end else if (!mode) begin
                        state <= S_RUN;
                    end
                end

                default: state <= S_EDIT;
            endcase
        end
    end

    // Registered display and status outputs, one cycle behind the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp   <= '0;
            pm     <= 1'b0;
            edit   <= 1'b0;
            cursor <= 3'd0;
            done   <= 1'b0;
        end else begin
            disp         <= tm;
            disp[I_HR_T] <= disp_hr_t;
            disp[I_HR_O] <= disp_hr_o;
            pm           <= !mode && (hour_bin >= 5'd12);
            edit         <= (state == S_EDIT);
            cursor       <= cursor_reg;
            done         <= (state == S_DONE);
        end
    end

    assign hr_t  = disp[I_HR_T];
    assign hr_o  = disp[I_HR_O];
    assign min_t = disp[I_MIN_T];
    assign min_o = disp[I_MIN_O];
    assign sec_t = disp[I_SEC_T];
    assign sec_o = disp[I_SEC_O];
    assign ms_h  = disp[I_MS_H];
    assign ms_t  = disp[I_MS_T];
    assign ms_o  = disp[I_MS_O];

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
Parametrised successor to the 12/24-hour clock block. Keeps an HH:MM:SS.mmm BCD time in one register set and runs it either as a time-of-day clock or as a countdown timer that latches a done flag. Ticks come from an internal prescaler, not from the raw clock. Edit mode has a cursor over hour, minute and (optionally) second digits, and button inputs are edge-detected inside the block. Outputs drive the seven-segment display mux and the LED status logic.

Parameters:
PRESCALE, 100000, clk cycles per 1 ms tick (>=2)
EDIT_SEC, 1, 1 = cursor also covers seconds digits (6 positions); 0 = hours/minutes only (4 positions)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
btn_l  in  1  left button, debounced level
btn_r  in  1  right button, debounced level
btn_c  in  1  centre button (increment), debounced level
btn_d  in  1  down button (decrement / clear), debounced level
fmt12  in  1  1 = 12-hour display, 0 = 24-hour
mode  in  1  0 = clock (count up), 1 = countdown timer
edit  out  1  1 while in edit mode
cursor  out  3  current edit digit index, 0..NPOS-1
hr_t, hr_o, min_t, min_o, sec_t, sec_o  out  4 each  displayed BCD digits
ms_h, ms_t, ms_o  out  4 each  millisecond BCD digits
pm  out  1  PM indicator
done  out  1  countdown reached zero
tick  out  1  one-cycle pulse per 1 ms tick

Behaviour:
- Reset (async, rst_n=0):
  - time = 00:00:00.000, edit=1, cursor=0, done=0, prescaler=0, button history regs=0.
  - All outputs are 0, including hr_t/hr_o even when fmt12=1.
- Edge detect: press_x = btn_x & ~btn_x_q. Only presses act; held buttons do nothing further.
- Prescaler:
  - Counts 0..PRESCALE-1 while running (edit=0 and done=0); otherwise held at 0.
  - tick asserts for the one cycle where count==PRESCALE-1, then the count wraps to 0.
  - First tick after leaving edit comes PRESCALE cycles later.
- FSM states: EDIT, RUN, DONE.
- EDIT:
  - ms digits forced 0. sec digits forced 0 when EDIT_SEC=0.
  - NPOS = 4 + 2*EDIT_SEC. Cursor map: 0 hr_t, 1 hr_o, 2 min_t, 3 min_o, 4 sec_t, 5 sec_o.
  - Priority per cycle: L > R > C > D; only one action per cycle.
  - L: cursor 0 exits to RUN; otherwise cursor-1.
  - R: cursor NPOS-1 exits to RUN with cursor=0; otherwise cursor+1.
  - C: increment the selected digit, wrapping to 0. D: decrement it, wrapping to its max.
  - Digit limits: hr_t 0..2; hr_o 0..9, or 0..3 when hr_t==2; tens of min/sec 0..5; ones 0..9.
  - When hr_t becomes 2 with hr_o>3, hr_o clamps to 3 on the same edge. When hr_t==2, hr_o decrement from 0 wraps to 3.
  - On exit, cursor resets to 0 and done clears.
- RUN, mode=0: on each tick, BCD increment with carry chain. 23:59:59.999 -> 00:00:00.000.
- RUN, mode=1:
  - On each tick, BCD decrement with borrow chain.
  - 00:00:00.001 -> 00:00:00.000 and the block enters DONE on the same edge.
  - Leaving edit with time all zero in mode=1 enters DONE on the next edge, with no tick.
- DONE:
  - done=1, time frozen, no ticks.
  - btn_l or btn_d leaves to EDIT. btn_d also clears the time.
  - mode going to 0 returns to RUN with done=0.
- RUN button actions:
  - btn_d clears the time to 0 and enters EDIT.
  - btn_l enters EDIT, keeping H:M:S (sec cleared if EDIT_SEC=0).
  - btn_d wins if both are pressed.
  - A press on the same cycle as a tick: the button action wins; the tick is dropped.
- Mode change in RUN takes effect at the next tick. The time value is not altered.
- Display (registered, 1-cycle latency from internal state):
  - mode=0, fmt12=1: hour 00->12; 01..12 unchanged; 13..19 -> 01..07; 20->08, 21->09, 22->10, 23->11.
  - mode=0: pm=1 iff internal hour >=12. pm is independent of fmt12.
  - mode=1: raw hours shown and pm=0, regardless of fmt12.
  - edit, cursor and done outputs are registered copies of state.

Test Plan:
- Reset mid-run at 12:34:56.789 -> all outputs 0 the same cycle; one cycle after release edit=1, cursor=0, time 00:00:00.000.
- PRESCALE=4, EDIT_SEC=1, edit to 23:59:59, press R at cursor 5 -> edit=0; 4 cycles later tick=1; after 1000 ticks reads 00:00:00.000 with one-cycle display lag.
- Edit hr_o=9, then set hr_t 1->2 via C -> hr_o reads 3. At hr_t=2, D on hr_o from 0 -> 3. C on min_t from 5 -> 0.
- fmt12=1 sweep of hours 00, 12, 13, 23 -> display 12/pm0, 12/pm1, 01/pm1, 11/pm1. Same with fmt12=0 -> 00, 12, 13, 23, pm unchanged.
- mode=1, set 00:00:01, exit -> 1000 ticks later time 00:00:00.000, done=1, tick stops; btn_l -> edit=1, done=0.
- btn_l and btn_d pressed together in RUN at 05:06:07.123 -> time 00:00:00.000, edit=1. A held btn_c in EDIT increments the digit once only.
